// File: rtl/demux_pkg.sv
// Shared constants for the 1:4 buffered demux: lane select encodings and default sizing.
package demux_pkg;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;
  localparam logic [1:0] LANE_D = 2'd3;

  localparam int unsigned DEFAULT_WIDTH = 64;
  localparam int unsigned DEFAULT_DEPTH = 2;

endpackage

// File: rtl/demux_lane_fifo.sv
// Single output lane of the demux: a small register FIFO with valid/ready on the read side.
module demux_lane_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so every lane output reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/demux_4by16_buf.sv
// Routes one 64-bit input stream to four independently buffered output lanes (A..D).
module demux_4by16_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic [WIDTH-1:0] outC,
  output logic [WIDTH-1:0] outD,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [3:0]       lane_full
);

  logic [3:0] push;

  // Ready depends only on the addressed lane's fullness; no pop-to-push bypass.
  assign in_ready = ~lane_full[in_sel];

  always_comb begin
    push = '0;
    if (in_valid && in_ready) begin
      unique case (in_sel)
        LANE_A:  push[0] = 1'b1;
        LANE_B:  push[1] = 1'b1;
        LANE_C:  push[2] = 1'b1;
        LANE_D:  push[3] = 1'b1;
        default: push    = '0;
      endcase
    end
  end

  demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[0]),
    .push_data (in_data),
    .pop       (out_ready[0]),
    .head      (outA),
    .valid     (out_valid[0]),
    .full      (lane_full[0])
  );

  demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[1]),
    .push_data (in_data),
    .pop       (out_ready[1]),
    .head      (outB),
    .valid     (out_valid[1]),
    .full      (lane_full[1])
  );

  demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[2]),
    .push_data (in_data),
    .pop       (out_ready[2]),
    .head      (outC),
    .valid     (out_valid[2]),
    .full      (lane_full[2])
  );

  demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_d (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[3]),
    .push_data (in_data),
    .pop       (out_ready[3]),
    .head      (outD),
    .valid     (out_valid[3]),
    .full      (lane_full[3])
  );

endmodule

// File: tb/tb_demux_4by16_buf.sv
// Scoreboard bench for demux_4by16_buf: per-lane expected-word queues vs. DUT lane outputs.
module tb_demux_4by16_buf;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_sel = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] outA, outB, outC, outD;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = '0;
  logic [3:0]       lane_full;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q [4][$];
  logic [63:0] outs [4];
  logic [63:0] cnts [4];

  demux_4by16_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outA      (outA),
    .outB      (outB),
    .outC      (outC),
    .outD      (outD),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_full (lane_full)
  );

  always #5 clk = ~clk;

  assign outs[0] = outA;
  assign outs[1] = outB;
  assign outs[2] = outC;
  assign outs[3] = outD;
  assign cnts[0] = 64'(dut.u_lane_a.count_q);
  assign cnts[1] = 64'(dut.u_lane_b.count_q);
  assign cnts[2] = 64'(dut.u_lane_c.count_q);
  assign cnts[3] = 64'(dut.u_lane_d.count_q);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each lane is a bounded queue; a push lands only if the target lane
  // had room before the edge, pops take from the front of any non-empty ready lane.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else begin
      int sel_l;
      bit acc;
      sel_l = int'(in_sel);
      acc = in_valid && (exp_q[sel_l].size() < int'(DEPTH));
      for (int i = 0; i < 4; i++)
        if (out_ready[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_front());
      if (acc) exp_q[sel_l].push_back(in_data);
    end
  end

  // Monitor: every cycle compare lane status and head data against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("valid[%0d]", i), 64'(out_valid[i]), 64'(exp_q[i].size() > 0));
        check($sformatf("full[%0d]", i), 64'(lane_full[i]),
              64'(exp_q[i].size() == int'(DEPTH)));
        check($sformatf("count[%0d]", i), cnts[i], 64'(exp_q[i].size()));
        if (exp_q[i].size() > 0 && out_valid[i])
          check($sformatf("data[%0d]", i), outs[i], exp_q[i][0]);
      end
    end
  end

  task automatic drive(input bit v, input logic [1:0] s, input logic [63:0] d,
                       input logic [3:0] r);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    check("in_ready", 64'(in_ready), 64'(exp_q[int'(s)].size() < int'(DEPTH)));
  endtask

  task automatic idle(input int n, input logic [3:0] r);
    for (int k = 0; k < n; k++) drive(1'b0, 2'd0, 64'd0, r);
  endtask

  initial begin
    bit accepted;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_full", 64'(lane_full), 64'h0);
    check("rst_outA", outA, 64'h0);
    check("rst_outB", outB, 64'h0);
    check("rst_outC", outC, 64'h0);
    check("rst_outD", outD, 64'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'h1);
    end

    // Single push to lane C
    drive(1'b1, 2'd2, 64'hDEAD_BEEF_0000_0001, 4'b0000);
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    check("c_valid", 64'(out_valid), 64'h4);
    check("c_data", outC, 64'hDEAD_BEEF_0000_0001);
    idle(2, 4'b1111);

    // Fill lane A, hold word 3 until space opens
    drive(1'b1, 2'd0, 64'd1, 4'b0000);
    drive(1'b1, 2'd0, 64'd2, 4'b0000);
    drive(1'b1, 2'd0, 64'd3, 4'b0000);
    check("a_full", 64'(lane_full[0]), 64'h1);
    check("a_in_ready", 64'(in_ready), 64'h0);
    in_valid = 1'b0;
    in_sel   = 2'd1;
    #1;
    check("b_in_ready", 64'(in_ready), 64'h1);
    in_sel   = 2'd0;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      drive(1'b1, 2'd0, 64'd3, 4'b0001);
      accepted = in_ready;
    end
    check("a_word3_accepted", 64'(accepted), 64'h1);
    idle(4, 4'b0001);
    check("a_drained", 64'(out_valid), 64'h0);

    // Lane B: simultaneous push and pop with one entry
    drive(1'b1, 2'd1, 64'h11, 4'b0000);
    drive(1'b1, 2'd1, 64'h22, 4'b0010);
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    check("b_swap_data", outB, 64'h22);
    check("b_swap_valid", 64'(out_valid[1]), 64'h1);
    check("b_swap_count", cnts[1], 64'h1);
    idle(2, 4'b1111);

    // Round robin with all consumers ready
    for (int k = 0; k < 8; k++) drive(1'b1, 2'(k % 4), 64'(k), 4'b1111);
    idle(3, 4'b1111);

    // Lanes A and D full, then asynchronous reset mid-cycle
    drive(1'b1, 2'd0, 64'hA0, 4'b0000);
    drive(1'b1, 2'd0, 64'hA1, 4'b0000);
    drive(1'b1, 2'd3, 64'hD0, 4'b0000);
    drive(1'b1, 2'd3, 64'hD1, 4'b0000);
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    check("pre_rst_full", 64'(lane_full), 64'h9);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'h0);
    check("async_full", 64'(lane_full), 64'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 64'h5, 4'b0000);
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    check("post_rst_outA", outA, 64'h5);
    check("post_rst_valid", 64'(out_valid), 64'h1);
    idle(2, 4'b1111);

    // Randomized traffic
    for (int k = 0; k < 500; k++)
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, 4'($urandom));
    idle(4, 4'b1111);
    check("final_empty", 64'(out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
